// File: rtl/path_pair_scheduler_pkg.sv
// Shared types and per-stage datapath functions for the path pair scheduler.
// Ops are bitwise, so callers pass zero-extended operands and truncate the result.
package path_sched_pkg;

   typedef enum logic {MODE_P1 = 1'b0, MODE_P2 = 1'b1} path_mode_e;

   localparam int PATH_LAT   = 2;
   localparam int PATH_MAX_W = 64;

   function automatic logic [PATH_MAX_W-1:0] path_stage0(
      input logic [PATH_MAX_W-1:0] a,
      input logic [PATH_MAX_W-1:0] b,
      input path_mode_e            mode
   );
      if (mode == MODE_P1) return ((a ^ b) & a) | b;
      else                 return ((a ^ ~b) & a) | b;
   endfunction

   function automatic logic [PATH_MAX_W-1:0] path_stage1(
      input logic [PATH_MAX_W-1:0] x2,
      input logic [PATH_MAX_W-1:0] a,
      input logic [PATH_MAX_W-1:0] b,
      input path_mode_e            mode
   );
      if (mode == MODE_P1) return (x2 & ~a) ^ b;
      else                 return (x2 & a) ^ ~b;
   endfunction

endpackage

// File: rtl/path_pair_scheduler_path_unit.sv
// Two-stage pipelined path unit carrying id/mode sideband; valids clear on reset
// and the response registers hold their last value between results.
module path_unit
   import path_sched_pkg::*;
#(
   parameter int WIDTH = 4,
   parameter int ID_W  = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  path_mode_e       in_mode,
   input  logic [ID_W-1:0]  in_id,
   output logic             out_valid,
   output logic [ID_W-1:0]  out_id,
   output path_mode_e       out_mode,
   output logic [WIDTH-1:0] out_data,
   output logic             stage_busy
);

   logic             vld_p0;
   logic [WIDTH-1:0] x2_p0;
   logic [WIDTH-1:0] a_p0;
   logic [WIDTH-1:0] b_p0;
   path_mode_e       mode_p0;
   logic [ID_W-1:0]  id_p0;

   logic             vld_p1;
   logic [WIDTH-1:0] data_p1;
   logic [ID_W-1:0]  id_p1;
   path_mode_e       mode_p1;

   logic [WIDTH-1:0] x2_d;
   logic [WIDTH-1:0] y_d;

   assign x2_d = WIDTH'(path_stage0(PATH_MAX_W'(in_a), PATH_MAX_W'(in_b), in_mode));
   assign y_d  = WIDTH'(path_stage1(PATH_MAX_W'(x2_p0), PATH_MAX_W'(a_p0),
                                    PATH_MAX_W'(b_p0), mode_p0));

   // stage 0 -> p0: winner operands captured so stage 1 never sees live inputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) vld_p0 <= 1'b0;
      else     vld_p0 <= in_valid;
   end

   always_ff @(posedge clk) begin
      if (in_valid) begin
         x2_p0   <= x2_d;
         a_p0    <= in_a;
         b_p0    <= in_b;
         mode_p0 <= in_mode;
         id_p0   <= in_id;
      end
   end

   // stage 1 -> p1: response registers, reset to zero and held while idle
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_p1  <= 1'b0;
         data_p1 <= '0;
         id_p1   <= '0;
         mode_p1 <= MODE_P1;
      end else begin
         vld_p1 <= vld_p0;
         if (vld_p0) begin
            data_p1 <= y_d;
            id_p1   <= id_p0;
            mode_p1 <= mode_p0;
         end
      end
   end

   assign out_valid  = vld_p1;
   assign out_id     = id_p1;
   assign out_mode   = mode_p1;
   assign out_data   = data_p1;
   // the response cycle itself is not "in flight"
   assign stage_busy = vld_p0;

endmodule

// File: rtl/path_pair_scheduler.sv
// Round-robin arbiter sharing one pipelined path unit among NREQ requesters,
// with a saturating accepted-request counter and an in-flight busy flag.
module path_pair_scheduler
   import path_sched_pkg::*;
#(
   parameter  int NREQ   = 4,
   parameter  int WIDTH  = 4,
   parameter  int GCNT_W = 16,
   localparam int ID_W   = $clog2(NREQ)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  cfg_enable,
   input  logic [NREQ-1:0]       req_valid,
   output logic [NREQ-1:0]       req_ready,
   input  logic [NREQ*WIDTH-1:0] req_a,
   input  logic [NREQ*WIDTH-1:0] req_b,
   input  logic [NREQ-1:0]       req_mode,
   output logic                  resp_valid,
   output logic [ID_W-1:0]       resp_id,
   output logic                  resp_mode,
   output logic [WIDTH-1:0]      resp_data,
   output logic                  busy,
   output logic [GCNT_W-1:0]     grant_cnt
);

   function automatic logic [GCNT_W-1:0] sat_inc(input logic [GCNT_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   logic [ID_W-1:0]  ptr;
   logic [NREQ-1:0]  grant;
   logic             found;
   logic [ID_W-1:0]  win_id;
   logic [WIDTH-1:0] win_a;
   logic [WIDTH-1:0] win_b;
   path_mode_e       win_mode;
   path_mode_e       unit_mode;

   // search from ptr upward, wrapping; held off entirely during reset
   always_comb begin
      grant    = '0;
      found    = 1'b0;
      win_id   = '0;
      win_a    = '0;
      win_b    = '0;
      win_mode = MODE_P1;
      if (!rst && cfg_enable) begin
         for (int k = 0; k < NREQ; k++) begin
            if (!found && req_valid[(int'(ptr) + k) % NREQ]) begin
               found    = 1'b1;
               grant[(int'(ptr) + k) % NREQ] = 1'b1;
               win_id   = ID_W'((int'(ptr) + k) % NREQ);
               win_a    = req_a[((int'(ptr) + k) % NREQ) * WIDTH +: WIDTH];
               win_b    = req_b[((int'(ptr) + k) % NREQ) * WIDTH +: WIDTH];
               win_mode = path_mode_e'(req_mode[(int'(ptr) + k) % NREQ]);
            end
         end
      end
   end

   assign req_ready = grant;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr       <= '0;
         grant_cnt <= '0;
      end else if (found) begin
         ptr       <= (int'(win_id) == NREQ - 1) ? '0 : win_id + 1'b1;
         grant_cnt <= sat_inc(grant_cnt);
      end
   end

   path_unit #(
      .WIDTH (WIDTH),
      .ID_W  (ID_W)
   ) u_path (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (found),
      .in_a       (win_a),
      .in_b       (win_b),
      .in_mode    (win_mode),
      .in_id      (win_id),
      .out_valid  (resp_valid),
      .out_id     (resp_id),
      .out_mode   (unit_mode),
      .out_data   (resp_data),
      .stage_busy (busy)
   );

   assign resp_mode = unit_mode;

endmodule

// File: tb/tb_path_pair_scheduler.sv
// Randomized bench for path_pair_scheduler against a queue-based reference model;
// a second instance with a 4-bit grant counter covers saturation.
module tb_path_pair_scheduler;

   localparam int NREQ  = 4;
   localparam int WIDTH = 4;
   localparam int ID_W  = 2;
   localparam int MASK  = (1 << WIDTH) - 1;

   logic                  clk = 1'b0;
   logic                  rst;
   logic                  cfg_enable;
   logic [NREQ-1:0]       req_valid;
   logic [NREQ-1:0]       req_mode;
   logic [NREQ*WIDTH-1:0] req_a;
   logic [NREQ*WIDTH-1:0] req_b;

   logic [NREQ-1:0]  req_ready,  req_ready4;
   logic             resp_valid, resp_valid4;
   logic [ID_W-1:0]  resp_id,    resp_id4;
   logic             resp_mode,  resp_mode4;
   logic [WIDTH-1:0] resp_data,  resp_data4;
   logic             busy,       busy4;
   logic [15:0]      grant_cnt;
   logic [3:0]       grant_cnt4;

   always #5 clk = ~clk;

   path_pair_scheduler #(.NREQ(NREQ), .WIDTH(WIDTH), .GCNT_W(16)) u_dut (
      .clk(clk), .rst(rst), .cfg_enable(cfg_enable),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_a(req_a), .req_b(req_b), .req_mode(req_mode),
      .resp_valid(resp_valid), .resp_id(resp_id), .resp_mode(resp_mode),
      .resp_data(resp_data), .busy(busy), .grant_cnt(grant_cnt)
   );

   path_pair_scheduler #(.NREQ(NREQ), .WIDTH(WIDTH), .GCNT_W(4)) u_dut4 (
      .clk(clk), .rst(rst), .cfg_enable(cfg_enable),
      .req_valid(req_valid), .req_ready(req_ready4),
      .req_a(req_a), .req_b(req_b), .req_mode(req_mode),
      .resp_valid(resp_valid4), .resp_id(resp_id4), .resp_mode(resp_mode4),
      .resp_data(resp_data4), .busy(busy4), .grant_cnt(grant_cnt4)
   );

   typedef struct {
      int due;
      int id;
      int mode;
      int data;
   } ent_t;

   ent_t q[$];
   int   mptr, gcnt, gcnt4, cyc;
   int   last_id, last_mode, last_data;
   int   checks = 0;
   int   errors = 0;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // P1 reduces to a&b, P2 to (a&b)^~b
   function automatic int ref_result(input int a, input int b, input int mode);
      if (mode == 0) return a & b & MASK;
      else           return ((a & b) ^ ~b) & MASK;
   endfunction

   task automatic model_clear();
      q.delete();
      mptr = 0; gcnt = 0; gcnt4 = 0;
      last_id = 0; last_mode = 0; last_data = 0;
   endtask

   task automatic cycle_step();
      int              g;
      logic [NREQ-1:0] exp_ready;
      ent_t            e;
      bit              rv;
      bit              exp_busy;
      #1;
      g = -1;
      exp_ready = '0;
      if (cfg_enable)
         for (int k = 0; k < NREQ; k++)
            if (g < 0 && req_valid[(mptr + k) % NREQ]) g = (mptr + k) % NREQ;
      if (g >= 0) exp_ready[g] = 1'b1;
      check_val("req_ready",  32'(req_ready),  32'(exp_ready));
      check_val("req_ready4", 32'(req_ready4), 32'(exp_ready));
      if (g >= 0) begin
         e.due  = cyc + 2;
         e.id   = g;
         e.mode = int'(req_mode[g]);
         e.data = ref_result(int'(req_a[g*WIDTH +: WIDTH]), int'(req_b[g*WIDTH +: WIDTH]), e.mode);
         q.push_back(e);
         mptr = (g + 1) % NREQ;
         if (gcnt < 65535) gcnt++;
         if (gcnt4 < 15) gcnt4++;
      end
      @(posedge clk);
      cyc++;
      #1;
      rv = 1'b0;
      if (q.size() > 0 && q[0].due == cyc) begin
         e = q.pop_front();
         rv = 1'b1;
         last_id = e.id; last_mode = e.mode; last_data = e.data;
      end
      exp_busy = (q.size() > 0) && (q[q.size()-1].due == cyc + 1);
      check_val("resp_valid",  32'(resp_valid),  32'(rv));
      check_val("resp_id",     32'(resp_id),     last_id);
      check_val("resp_mode",   32'(resp_mode),   last_mode);
      check_val("resp_data",   32'(resp_data),   last_data);
      check_val("resp_data4",  32'(resp_data4),  last_data);
      check_val("busy",        32'(busy),        32'(exp_busy));
      check_val("grant_cnt",   32'(grant_cnt),   gcnt);
      check_val("grant_cnt4",  32'(grant_cnt4),  gcnt4);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      cfg_enable = 1'b1;
      req_valid = '1;
      #2;
      check_val("rst_ready",     32'(req_ready),  0);
      check_val("rst_resp_vld",  32'(resp_valid), 0);
      check_val("rst_resp_id",   32'(resp_id),    0);
      check_val("rst_resp_mode", 32'(resp_mode),  0);
      check_val("rst_resp_data", 32'(resp_data),  0);
      check_val("rst_busy",      32'(busy),       0);
      check_val("rst_gcnt",      32'(grant_cnt),  0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      req_valid = '0;
      model_clear();
   endtask

   task automatic set_req(input int i, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic m);
      req_a[i*WIDTH +: WIDTH] = a;
      req_b[i*WIDTH +: WIDTH] = b;
      req_mode[i] = m;
   endtask

   initial begin
      rst = 1'b1; cfg_enable = 1'b0; req_valid = '0; req_mode = '0; req_a = '0; req_b = '0;
      cyc = 0;
      model_clear();
      do_reset();

      // single request, both modes
      set_req(0, 4'b1100, 4'b1010, 1'b0);
      req_valid = 4'b0001;
      cycle_step();
      req_valid = '0;
      cycle_step();
      check_val("t1_p1_data", 32'(resp_data), 32'h8);
      set_req(0, 4'b1100, 4'b1010, 1'b1);
      req_valid = 4'b0001;
      cycle_step();
      req_valid = '0;
      cycle_step();
      check_val("t1_p2_data", 32'(resp_data), 32'hd);

      // all requesters valid every cycle
      do_reset();
      for (int i = 0; i < NREQ; i++) set_req(i, WIDTH'($urandom), WIDTH'($urandom), 1'($urandom));
      req_valid = '1;
      repeat (9) cycle_step();

      // pointer skips idle requesters
      do_reset();
      req_valid = 4'b0010;
      cycle_step();
      req_valid = 4'b1001;
      #1;
      check_val("t3_ready_3", 32'(req_ready), 32'h8);
      cycle_step();
      cycle_step();
      req_valid = '0;
      repeat (3) cycle_step();

      // streaming then enable drop
      req_valid = '1;
      repeat (5) cycle_step();
      cfg_enable = 1'b0;
      repeat (4) cycle_step();
      cfg_enable = 1'b1;

      // reset with entries in flight
      req_valid = '1;
      repeat (2) cycle_step();
      rst = 1'b1;
      #1;
      check_val("t5_resp_drop", 32'(resp_valid), 0);
      check_val("t5_busy_drop", 32'(busy), 0);
      do_reset();
      req_valid = '0;
      repeat (4) cycle_step();
      req_valid = '1;
      cycle_step();

      // randomized traffic
      for (int n = 0; n < 400; n++) begin
         req_valid  = NREQ'($urandom);
         req_mode   = NREQ'($urandom);
         req_a      = (NREQ*WIDTH)'($urandom);
         req_b      = (NREQ*WIDTH)'($urandom);
         cfg_enable = ($urandom_range(0, 9) != 0);
         cycle_step();
      end
      req_valid = '0;
      repeat (3) cycle_step();
      check_val("t6_gcnt4_sat", 32'(grant_cnt4), 15);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
